// File: rtl/enemy_collision_detector.sv
// Enemy-vs-player collision detector.
// Once per running frame the player and three enemy centres are latched,
// each enemy is tested in turn for box overlap against the player (one per
// clock), and a counted hit costs a life and starts an invulnerability window.
module enemy_collision_detector #(
  parameter int HIT_RADIUS      = 20,
  parameter int LIVES           = 3,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gamemenu,
  input  logic       gamerun,
  input  logic       gamepause,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] e0_x,
  input  logic [9:0] e0_y,
  input  logic [9:0] e1_x,
  input  logic [9:0] e1_y,
  input  logic [9:0] e2_x,
  input  logic [9:0] e2_y,
  output logic       hit_pulse,
  output logic [1:0] hit_idx,
  output logic [2:0] lives,
  output logic       invulnerable,
  output logic       game_over,
  output logic       busy
);

  localparam logic [2:0]  S_IDLE     = 3'd0;
  localparam logic [2:0]  S_CHECK0   = 3'd1;
  localparam logic [2:0]  S_CHECK1   = 3'd2;
  localparam logic [2:0]  S_CHECK2   = 3'd3;
  localparam logic [2:0]  S_RESOLVE  = 3'd4;
  localparam logic [2:0]  S_GAMEOVER = 3'd5;

  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]  COOL_INIT  = 8'(COOLDOWN_FRAMES);
  localparam logic [10:0] RADIUS     = 11'(HIT_RADIUS);

  logic [2:0] r_state;
  logic [2:0] r_lives;
  logic [7:0] r_cd;
  logic       r_hit_pulse;
  logic [1:0] r_hit_idx;
  logic       r_game_over;
  logic       r_any;
  logic [1:0] r_first;

  // Shadow copies of the positions, frozen for the duration of a scan
  logic [9:0] r_px;
  logic [9:0] r_py;
  logic [9:0] r_ex [3];
  logic [9:0] r_ey [3];

  logic              w_menu;
  logic              w_run;
  logic              w_accept;
  logic [1:0]        w_idx;
  logic [9:0]        w_ex;
  logic [9:0]        w_ey;
  logic signed [10:0] w_dx_s;
  logic signed [10:0] w_dy_s;
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic              w_overlap;
  logic              w_hit_any;
  logic [1:0]        w_hit_first;

  // Magnitude of an 11-bit difference of two zero-extended 10-bit values;
  // the range is +/-1023 so negation never overflows.
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  assign w_menu   = gamemenu & ~gamerun & ~gamepause;
  assign w_run    = ~gamemenu & gamerun & ~gamepause;
  assign w_accept = (r_state == S_IDLE) && frame_tick && w_run;

  // Pick the enemy under test from the current check state
  always_comb begin
    w_idx = 2'd0;
    case (r_state)
      S_CHECK1: w_idx = 2'd1;
      S_CHECK2: w_idx = 2'd2;
      default:  w_idx = 2'd0;
    endcase
  end

  assign w_ex   = r_ex[w_idx];
  assign w_ey   = r_ey[w_idx];
  assign w_dx_s = $signed({1'b0, r_px}) - $signed({1'b0, w_ex});
  assign w_dy_s = $signed({1'b0, r_py}) - $signed({1'b0, w_ey});
  assign w_dx   = abs11(w_dx_s);
  assign w_dy   = abs11(w_dy_s);
  assign w_overlap = (w_dx < RADIUS) && (w_dy < RADIUS);

  // Final verdict once the last enemy has been compared; an earlier hit wins
  assign w_hit_any   = r_any | w_overlap;
  assign w_hit_first = r_any ? r_first : 2'd2;

  // Latch positions when a frame scan is accepted (data path, no reset)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_px    <= player_x;
      r_py    <= player_y;
      r_ex[0] <= e0_x;
      r_ey[0] <= e0_y;
      r_ex[1] <= e1_x;
      r_ey[1] <= e1_y;
      r_ex[2] <= e2_x;
      r_ey[2] <= e2_y;
    end
  end

  // Scan sequencer, life counter and cooldown; menu reload overrides everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lives     <= LIVES_INIT;
      r_cd        <= '0;
      r_hit_pulse <= 1'b0;
      r_hit_idx   <= 2'd0;
      r_game_over <= 1'b0;
      r_any       <= 1'b0;
      r_first     <= 2'd0;
    end else begin
      r_hit_pulse <= 1'b0;
      if (w_menu) begin
        r_state     <= S_IDLE;
        r_lives     <= LIVES_INIT;
        r_cd        <= '0;
        r_hit_idx   <= 2'd0;
        r_game_over <= 1'b0;
        r_any       <= 1'b0;
        r_first     <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              if (r_cd != 8'd0) r_cd <= r_cd - 8'd1;
              r_any   <= 1'b0;
              r_first <= 2'd0;
              r_state <= S_CHECK0;
            end
          end
          S_CHECK0, S_CHECK1: begin
            if (w_overlap && !r_any) begin
              r_any   <= 1'b1;
              r_first <= w_idx;
            end
            r_state <= (r_state == S_CHECK0) ? S_CHECK1 : S_CHECK2;
          end
          S_CHECK2: begin
            // Result registered here so hit_pulse is visible during RESOLVE
            if (w_hit_any && (r_cd == 8'd0) && (r_lives != 3'd0)) begin
              r_lives     <= r_lives - 3'd1;
              r_hit_pulse <= 1'b1;
              r_hit_idx   <= w_hit_first;
              r_cd        <= COOL_INIT;
              if (r_lives == 3'd1) r_game_over <= 1'b1;
            end
            r_state <= S_RESOLVE;
          end
          S_RESOLVE: begin
            r_state <= r_game_over ? S_GAMEOVER : S_IDLE;
          end
          S_GAMEOVER: begin
            r_state <= S_GAMEOVER;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign hit_pulse    = r_hit_pulse;
  assign hit_idx      = r_hit_idx;
  assign lives        = r_lives;
  assign invulnerable = (r_cd != 8'd0);
  assign game_over    = r_game_over;
  assign busy         = (r_state >= S_CHECK0) && (r_state <= S_RESOLVE);

endmodule

// File: tb/tb_enemy_collision_detector.sv
// Self-checking bench for enemy_collision_detector: directed scenarios plus
// randomized frames compared against a frame-level reference model.
module tb_enemy_collision_detector;

  localparam int R    = 20;
  localparam int NLIV = 3;
  localparam int COOL = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       gamemenu, gamerun, gamepause, frame_tick;
  logic [9:0] player_x, player_y, e0_x, e0_y, e1_x, e1_y, e2_x, e2_y;
  logic       hit_pulse;
  logic [1:0] hit_idx;
  logic [2:0] lives;
  logic       invulnerable, game_over, busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state (one update per accepted frame)
  int m_lives, m_cd, m_idx;
  bit m_go;

  enemy_collision_detector #(.HIT_RADIUS(R), .LIVES(NLIV), .COOLDOWN_FRAMES(COOL)) dut (
    .clk(clk), .reset(reset), .gamemenu(gamemenu), .gamerun(gamerun),
    .gamepause(gamepause), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y),
    .e0_x(e0_x), .e0_y(e0_y), .e1_x(e1_x), .e1_y(e1_y), .e2_x(e2_x), .e2_y(e2_y),
    .hit_pulse(hit_pulse), .hit_idx(hit_idx), .lives(lives),
    .invulnerable(invulnerable), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic model_reset();
    m_lives = NLIV; m_cd = 0; m_idx = 0; m_go = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_pos(input int px, input int py, input int a0, input int b0,
                         input int a1, input int b1, input int a2, input int b2);
    player_x = 10'(px); player_y = 10'(py);
    e0_x = 10'(a0); e0_y = 10'(b0);
    e1_x = 10'(a1); e1_y = 10'(b1);
    e2_x = 10'(a2); e2_y = 10'(b2);
  endtask

  task automatic set_run();
    gamemenu = 1'b0; gamerun = 1'b1; gamepause = 1'b0;
  endtask

  task automatic do_menu(input string tag);
    gamemenu = 1'b1; gamerun = 1'b0; gamepause = 1'b0;
    step();
    model_reset();
    chk({tag, ".lives"}, 32'(lives), NLIV);
    chk({tag, ".go"}, 32'(game_over), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".inv"}, 32'(invulnerable), 0);
    set_run();
  endtask

  // One frame tick; model decides acceptance and hit, DUT is checked over 5 cycles
  task automatic do_frame(input string tag, input bit run, output bit hit);
    bit acc;
    int ovl;
    int ex[3], ey[3];
    ex[0] = int'(e0_x); ey[0] = int'(e0_y);
    ex[1] = int'(e1_x); ey[1] = int'(e1_y);
    ex[2] = int'(e2_x); ey[2] = int'(e2_y);
    gamemenu = 1'b0; gamerun = 1'b1; gamepause = !run;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    acc = run && !m_go;
    hit = 1'b0;
    if (acc) begin
      if (m_cd > 0) m_cd--;
      ovl = -1;
      for (int i = 0; i < 3; i++)
        if (ovl < 0 && absdiff(int'(player_x), ex[i]) < R && absdiff(int'(player_y), ey[i]) < R)
          ovl = i;
      if (ovl >= 0 && m_cd == 0) begin
        hit = 1'b1;
        m_lives--;
        m_idx = ovl;
        m_cd = COOL;
        if (m_lives == 0) m_go = 1'b1;
      end
    end
    for (int c = 1; c <= 5; c++) begin
      chk({tag, ".busy"}, 32'(busy), 32'(acc && c <= 4));
      chk({tag, ".pulse"}, 32'(hit_pulse), 32'(hit && c == 4));
      if (c >= 4) begin
        chk({tag, ".lives"}, 32'(lives), m_lives);
        chk({tag, ".idx"}, 32'(hit_idx), m_idx);
        chk({tag, ".go"}, 32'(game_over), 32'(m_go));
        chk({tag, ".inv"}, 32'(invulnerable), 32'(m_cd != 0));
      end
      step();
    end
    gamepause = 1'b0;
  endtask

  initial begin
    bit h;
    int hit_t[$];
    int px, py, q[6];

    reset = 1'b1; frame_tick = 1'b0;
    gamemenu = 1'b0; gamerun = 1'b0; gamepause = 1'b0;
    set_pos(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) step();
    chk("rst.lives", 32'(lives), NLIV);
    chk("rst.pulse", 32'(hit_pulse), 0);
    chk("rst.idx", 32'(hit_idx), 0);
    chk("rst.go", 32'(game_over), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.inv", 32'(invulnerable), 0);
    reset = 1'b0;
    step();

    // Basic hit on enemy 0
    do_menu("t1m");
    set_pos(300, 200, 300, 200, 450, 100, 200, 300);
    do_frame("t1", 1'b1, h);
    chk("t1.hit", 32'(h), 1);
    chk("t1.idx_c", 32'(hit_idx), 0);
    chk("t1.lives_c", 32'(lives), 2);
    chk("t1.inv_c", 32'(invulnerable), 1);

    // Strict radius boundaries on enemy 1
    do_menu("t2m");
    set_pos(100, 100, 900, 900, 119, 100, 900, 50);
    do_frame("t2a", 1'b1, h);
    chk("t2a.hit", 32'(h), 1);
    chk("t2a.idx_c", 32'(hit_idx), 1);
    do_menu("t2m");
    set_pos(100, 100, 900, 900, 120, 100, 900, 50);
    do_frame("t2b", 1'b1, h);
    chk("t2b.hit", 32'(h), 0);
    set_pos(100, 100, 900, 900, 81, 81, 900, 50);
    do_frame("t2c", 1'b1, h);
    chk("t2c.hit", 32'(h), 1);

    // Held overlap: cooldown spacing, pause freezes cooldown, lives run out
    do_menu("t3m");
    set_pos(300, 200, 700, 700, 10, 900, 305, 195);
    for (int t = 1; t <= 121; t++) begin
      if (t == 30) begin
        for (int k = 0; k < 5; k++) begin
          do_frame("t5p", 1'b0, h);
          chk("t5p.hit", 32'(h), 0);
        end
      end
      do_frame("t3", 1'b1, h);
      if (h) hit_t.push_back(t);
    end
    chk("t3.npulse", 32'(hit_t.size()), 3);
    if (hit_t.size() >= 2) chk("t3.spacing", 32'(hit_t[1] - hit_t[0]), COOL);
    chk("t4.lives", 32'(lives), 0);
    chk("t4.go", 32'(game_over), 1);
    for (int k = 0; k < 3; k++) begin
      do_frame("t4after", 1'b1, h);
      chk("t4after.hit", 32'(h), 0);
    end
    do_menu("t4m");

    // Tick while busy is dropped
    set_pos(500, 500, 10, 10, 20, 20, 30, 30);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    set_pos(500, 500, 500, 500, 20, 20, 30, 30);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("t5busy.pulse", 32'(hit_pulse), 0);
      step();
    end
    chk("t5busy.busy", 32'(busy), 0);
    chk("t5busy.lives", 32'(lives), NLIV);
    do_frame("t5next", 1'b1, h);
    chk("t5next.hit", 32'(h), 1);

    // Async reset in CHECK1
    do_menu("t6m");
    set_pos(300, 200, 300, 200, 900, 900, 900, 900);
    do_frame("t6pre", 1'b1, h);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("t6.busy_in", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t6r.busy", 32'(busy), 0);
    chk("t6r.lives", 32'(lives), NLIV);
    chk("t6r.pulse", 32'(hit_pulse), 0);
    chk("t6r.inv", 32'(invulnerable), 0);
    step();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      chk("t6r.quiet", 32'(hit_pulse), 0);
      step();
    end

    // Menu in CHECK1
    do_frame("t6pre2", 1'b1, h);
    chk("t6pre2.hit", 32'(h), 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    gamemenu = 1'b1; gamerun = 1'b0; gamepause = 1'b0;
    step();
    model_reset();
    chk("t6m.busy", 32'(busy), 0);
    chk("t6m.lives", 32'(lives), NLIV);
    chk("t6m.inv", 32'(invulnerable), 0);
    set_run();
    for (int c = 0; c < 4; c++) begin
      chk("t6m.quiet", 32'(hit_pulse), 0);
      step();
    end

    // Randomized frames against the model
    do_menu("rndm");
    for (int n = 0; n < 200; n++) begin
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          q[2*i]   = clamp(px + int'($urandom_range(0, 48)) - 24);
          q[2*i+1] = clamp(py + int'($urandom_range(0, 48)) - 24);
        end else begin
          q[2*i]   = $urandom_range(0, 1023);
          q[2*i+1] = $urandom_range(0, 1023);
        end
      end
      set_pos(px, py, q[0], q[1], q[2], q[3], q[4], q[5]);
      do_frame("rnd", ($urandom_range(0, 7) != 0), h);
      if (m_go) do_menu("rndgo");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
